// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode, entry-state and entry-stage constants for the
//               front-panel sequencer and the execute core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_ST   = 4'b1111;

  localparam logic [2:0] S_OP    = 3'd0;
  localparam logic [2:0] S_A     = 3'd1;
  localparam logic [2:0] S_B     = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;

  localparam logic [1:0] STAGE_OP   = 2'd0;
  localparam logic [1:0] STAGE_A    = 2'd1;
  localparam logic [1:0] STAGE_B    = 2'd2;
  localparam logic [1:0] STAGE_EXEC = 2'd3;

  function automatic logic is_legal_opcode(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_NAND,
      OP_NOR, OP_XOR, OP_LD,  OP_ST: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchroniser, debounce counter and one-shot for a raw key.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_arm;
  logic             w_hit;

  assign w_hit   = (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) && r_arm;
  assign o_press = w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_arm   <= 1'b1;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (!r_sync2) begin
        r_cnt <= '0;
        r_arm <= 1'b1;
      end else begin
        // Saturate so a very long hold can never wrap back onto the trigger value.
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        if (w_hit) r_arm <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_entry_sequencer
// Description : Collects opcode/A/B from the switches on successive enter
//               presses and issues one instruction over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_entry_sequencer
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int CNT_W           = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Sw,
  input  logic       Button0,
  input  logic       Button5,
  input  logic       Instr_Ready,
  output logic       Instr_Valid,
  output logic [3:0] Opcode,
  output logic [3:0] Op_A,
  output logic [3:0] Op_B,
  output logic [1:0] Entry_Stage,
  output logic       Opcode_Err
);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [7:0] r_sw;
  logic       w_press;
  logic       w_abort;
  logic       w_legal;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn0 (
    .clk     (Clock),
    .rst_n   (Reset),
    .i_btn   (Button0),
    .o_press (w_press)
  );

  // The handshake must never be broken, so abort is masked during issue.
  assign w_abort = !Button5 && (r_state != S_ISSUE);
  assign w_legal = is_legal_opcode(r_sw[3:0]);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_OP;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_OP:    if (w_press && w_legal) w_next_state = S_A;
      S_A:     if (w_press) w_next_state = S_B;
      S_B:     if (w_press) w_next_state = S_EXEC;
      S_EXEC:  if (w_press) w_next_state = S_ISSUE;
      S_ISSUE: if (Instr_Ready) w_next_state = S_OP;
      default: w_next_state = S_OP;
    endcase
    if (w_abort) w_next_state = S_OP;
  end

  always_comb begin
    Instr_Valid = (r_state == S_ISSUE);
    case (r_state)
      S_OP:    Entry_Stage = STAGE_OP;
      S_A:     Entry_Stage = STAGE_A;
      S_B:     Entry_Stage = STAGE_B;
      default: Entry_Stage = STAGE_EXEC;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_sw       <= '0;
      Opcode     <= '0;
      Op_A       <= '0;
      Op_B       <= '0;
      Opcode_Err <= 1'b0;
    end else begin
      r_sw <= Sw;
      if (w_abort) begin
        Opcode <= '0;
        Op_A   <= '0;
        Op_B   <= '0;
      end else if (w_press) begin
        case (r_state)
          S_OP: begin
            if (w_legal) begin
              Opcode     <= r_sw[3:0];
              Opcode_Err <= 1'b0;
            end else begin
              Opcode_Err <= 1'b1;
            end
          end
          S_A:     Op_A <= r_sw[7:4];
          S_B:     Op_B <= r_sw[7:4];
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_entry_sequencer
// Description : Directed scoreboard bench for instr_entry_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_entry_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] Sw = 8'h00;
  logic       Button0 = 1'b0;
  logic       Button5 = 1'b1;
  logic       Instr_Ready = 1'b0;
  logic       Instr_Valid;
  logic [3:0] Opcode, Op_A, Op_B;
  logic [1:0] Entry_Stage;
  logic       Opcode_Err;

  logic       b0_4 = 1'b0;
  logic       valid_4, err_4;
  logic [3:0] opc_4, opa_4, opb_4;
  logic [1:0] stage_4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         cycles;
  } exp_t;

  exp_t sb_q[$];
  int   vcnt = 0;

  always #5 Clock = ~Clock;

  instr_entry_sequencer #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Sw          (Sw),
    .Button0     (Button0),
    .Button5     (Button5),
    .Instr_Ready (Instr_Ready),
    .Instr_Valid (Instr_Valid),
    .Opcode      (Opcode),
    .Op_A        (Op_A),
    .Op_B        (Op_B),
    .Entry_Stage (Entry_Stage),
    .Opcode_Err  (Opcode_Err)
  );

  instr_entry_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut4 (
    .Clock       (Clock),
    .Reset       (Reset),
    .Sw          (Sw),
    .Button0     (b0_4),
    .Button5     (Button5),
    .Instr_Ready (Instr_Ready),
    .Instr_Valid (valid_4),
    .Opcode      (opc_4),
    .Op_A        (opa_4),
    .Op_B        (opb_4),
    .Entry_Stage (stage_4),
    .Opcode_Err  (err_4)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic press(input logic [7:0] sw);
    Sw = sw;
    tick();
    Button0 = 1'b1;
    repeat (4) tick();
    Button0 = 1'b0;
    repeat (4) tick();
  endtask

  // Monitor: every valid cycle is compared against the head of the scoreboard;
  // the entry retires on the cycle the core accepts it.
  always @(negedge Clock) begin
    if (!Reset) begin
      sb_q.delete();
      vcnt = 0;
    end else if (Instr_Valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        vcnt++;
        check("issue_opcode", Opcode, sb_q[0].op);
        check("issue_op_a", Op_A, sb_q[0].a);
        check("issue_op_b", Op_B, sb_q[0].b);
        if (Instr_Ready) begin
          check("issue_valid_cycles", vcnt, sb_q[0].cycles);
          void'(sb_q.pop_front());
          vcnt = 0;
        end
      end
    end
  end

  initial begin
    int found;
    int lat;

    repeat (3) tick();
    check("rst_valid", Instr_Valid, 0);
    check("rst_stage", Entry_Stage, 0);
    check("rst_opcode", Opcode, 0);
    check("rst_err", Opcode_Err, 0);
    Reset = 1'b1;
    tick();

    // ADD 7,2 with the core always ready.
    Instr_Ready = 1'b1;
    press(8'h01);
    check("t1_stage_a", Entry_Stage, 1);
    press(8'h71);
    press(8'h21);
    check("t1_stage_exec", Entry_Stage, 3);
    sb_q.push_back('{op: 4'b0001, a: 4'd7, b: 4'd2, cycles: 1});
    press(8'h00);
    check("t1_stage_done", Entry_Stage, 0);
    check("t1_sb_drained", sb_q.size(), 0);

    // SUB 14,8 with the core stalling; two presses during the stall are dropped.
    Instr_Ready = 1'b0;
    press(8'h03);
    press(8'hE3);
    press(8'h83);
    sb_q.push_back('{op: 4'b0011, a: 4'd14, b: 4'd8, cycles: 11});
    Button0 = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (Instr_Valid) found = 1;
    end
    check("t2_valid_seen", found, 1);
    for (int t = 1; t <= 10; t++) begin
      Button0 = (t == 3 || t == 6);
      check("t2_stage_hold", Entry_Stage, 3);
      tick();
    end
    Instr_Ready = 1'b1;
    tick();
    Instr_Ready = 1'b0;
    check("t2_valid_dropped", Instr_Valid, 0);
    check("t2_stage_done", Entry_Stage, 0);
    check("t2_opcode_kept", Opcode, 4'b0011);
    check("t2_op_a_kept", Op_A, 14);
    check("t2_op_b_kept", Op_B, 8);
    repeat (6) tick();
    check("t2_no_queued_press", Entry_Stage, 0);
    check("t2_sb_drained", sb_q.size(), 0);

    // Illegal opcode, then XOR 9,13.
    Instr_Ready = 1'b1;
    press(8'h05);
    check("t3_err_set", Opcode_Err, 1);
    check("t3_stage_op", Entry_Stage, 0);
    press(8'h0B);
    check("t3_err_clear", Opcode_Err, 0);
    check("t3_stage_a", Entry_Stage, 1);
    press(8'h9B);
    press(8'hDB);
    sb_q.push_back('{op: 4'b1011, a: 4'd9, b: 4'd13, cycles: 1});
    press(8'h00);
    check("t3_stage_done", Entry_Stage, 0);
    check("t3_sb_drained", sb_q.size(), 0);

    // Abort after MUL and operand A.
    press(8'h07);
    press(8'h27);
    check("t4_stage_b", Entry_Stage, 2);
    check("t4_op_a", Op_A, 2);
    Button5 = 1'b0;
    tick();
    check("t4_abort_stage", Entry_Stage, 0);
    check("t4_abort_opcode", Opcode, 0);
    check("t4_abort_op_a", Op_A, 0);
    check("t4_abort_op_b", Op_B, 0);
    press(8'h01);
    check("t4_hold_stage", Entry_Stage, 0);
    check("t4_hold_opcode", Opcode, 0);
    Button5 = 1'b1;
    tick();

    // Four-cycle debounce: a 3-cycle blip is rejected, a long hold advances once.
    Sw = 8'h01;
    tick();
    b0_4 = 1'b1;
    repeat (3) tick();
    b0_4 = 1'b0;
    repeat (8) tick();
    check("t5_short_rejected", stage_4, 0);
    b0_4 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (stage_4 != 2'd0 && lat == 0) lat = i;
    end
    b0_4 = 1'b0;
    repeat (8) tick();
    // Pulse is live 6 cycles after the rise; the stage register shows it one edge later.
    check("t5_latency", lat, 7);
    check("t5_single_advance", stage_4, 1);

    // Reset while the core stalls an issued instruction.
    Instr_Ready = 1'b0;
    press(8'h01);
    press(8'h21);
    press(8'h31);
    sb_q.push_back('{op: 4'b0001, a: 4'd2, b: 4'd3, cycles: 0});
    Button0 = 1'b1;
    repeat (6) tick();
    check("t6_valid_before_reset", Instr_Valid, 1);
    @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    check("t6_async_valid", Instr_Valid, 0);
    check("t6_async_opcode", Opcode, 0);
    check("t6_async_op_a", Op_A, 0);
    check("t6_async_op_b", Op_B, 0);
    check("t6_async_stage", Entry_Stage, 0);
    check("t6_async_err", Opcode_Err, 0);
    Button0 = 1'b0;
    repeat (2) tick();
    Reset = 1'b1;
    repeat (3) tick();
    check("t6_post_stage", Entry_Stage, 0);
    check("t6_post_valid", Instr_Valid, 0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
